// File: rtl/sys_cmd_master.sv
`timescale 1ns/1ps
// sys_cmd_master: serializes host commands into UART frames and assembles the reply.
// Define SYS_CMD_TIMEOUT_EN to add the response timeout counter and TOUT state.
module sys_cmd_master #(
   parameter int D_Width   = 8,
   parameter int ALU_O_W   = D_Width*2,
   parameter int Addr_Size = 4,
   parameter int TO_W      = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 Cmd_Valid,
   output logic                 Cmd_Ready,
   input  logic [1:0]           Cmd_Op,
   input  logic [Addr_Size-1:0] Cmd_Addr,
   input  logic [D_Width-1:0]   Cmd_Data,
   input  logic [D_Width-1:0]   Cmd_OPA,
   input  logic [D_Width-1:0]   Cmd_OPB,
   input  logic [3:0]           Cmd_FUN,
   input  logic [TO_W-1:0]      Timeout_Lim,
   output logic [D_Width-1:0]   TX_P_DATA,
   output logic                 TX_D_VLD,
   input  logic                 TX_Busy,
   input  logic [D_Width-1:0]   RX_P_DATA,
   input  logic                 RX_D_VLD,
   output logic                 Rsp_Valid,
   output logic [ALU_O_W-1:0]   Rsp_Data,
   output logic                 Rsp_Timeout
);

   typedef enum logic [2:0] {
      S_IDLE, S_SEND, S_GAP, S_WAIT, S_DONE, S_TOUT
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [1:0]           op_q;
   logic [Addr_Size-1:0] addr_q;
   logic [D_Width-1:0]   data_q;
   logic [D_Width-1:0]   opa_q;
   logic [D_Width-1:0]   opb_q;
   logic [3:0]           fun_q;
   logic [1:0]           idx_q;
   logic                 ridx_q;
   logic [ALU_O_W-1:0]   rsp_buf;
   logic [ALU_O_W-1:0]   buf_nxt;
   logic [1:0]           last_idx;
   logic                 rlast;
   logic [D_Width-1:0]   frame_byte;
   logic                 accept;
   logic                 xfer;
   logic                 tx_last;
   logic                 rx_take;

   assign accept  = (state == S_IDLE) && Cmd_Valid;
   assign xfer    = (state == S_SEND) && !TX_Busy;
   assign tx_last = (idx_q == last_idx);
   assign rx_take = (state == S_WAIT) && RX_D_VLD;

   always_comb begin
      last_idx = 2'd1;
      rlast    = 1'b1;
      case (op_q)
         2'b00:   last_idx = 2'd2;
         2'b01: begin
            last_idx = 2'd1;
            rlast    = 1'b0;
         end
         2'b10:   last_idx = 2'd3;
         default: last_idx = 2'd1;
      endcase
   end

   always_comb begin
      frame_byte = '0;
      case ({op_q, idx_q})
         4'b00_00: frame_byte = D_Width'(8'hAA);
         4'b00_01: frame_byte = D_Width'(addr_q);
         4'b00_10: frame_byte = data_q;
         4'b01_00: frame_byte = D_Width'(8'hBB);
         4'b01_01: frame_byte = D_Width'(addr_q);
         4'b10_00: frame_byte = D_Width'(8'hCC);
         4'b10_01: frame_byte = opa_q;
         4'b10_10: frame_byte = opb_q;
         4'b10_11: frame_byte = D_Width'(fun_q);
         4'b11_00: frame_byte = D_Width'(8'hDD);
         4'b11_01: frame_byte = D_Width'(fun_q);
         default:  frame_byte = '0;
      endcase
   end

   // Responses arrive LSB first; ridx_q selects the byte lane.
   always_comb begin
      buf_nxt = rsp_buf;
      if (rx_take) begin
         if (ridx_q)
            buf_nxt[2*D_Width-1:D_Width] = RX_P_DATA;
         else
            buf_nxt[D_Width-1:0] = RX_P_DATA;
      end
   end

`ifdef SYS_CMD_TIMEOUT_EN
   logic [TO_W-1:0] cnt;
   logic            tout_hit;

   assign tout_hit = (Timeout_Lim != '0) &&
                     (cnt == Timeout_Lim - TO_W'(1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         cnt <= '0;
      else if (state != S_WAIT || RX_D_VLD)
         cnt <= '0;
      else
         cnt <= cnt + TO_W'(1);
   end
`else
   logic unused_lim;
   assign unused_lim = ^Timeout_Lim;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (Cmd_Valid) state_nxt = S_SEND;
         S_SEND: begin
            if (!TX_Busy) begin
               if (!tx_last)
                  state_nxt = S_GAP;
               else if (op_q == 2'b00)
                  state_nxt = S_DONE;
               else
                  state_nxt = S_WAIT;
            end
         end
         S_GAP: state_nxt = S_SEND;
         S_WAIT: begin
            if (RX_D_VLD) begin
               if (ridx_q == rlast) state_nxt = S_DONE;
            end
`ifdef SYS_CMD_TIMEOUT_EN
            else if (tout_hit) state_nxt = S_TOUT;
`endif
         end
         S_DONE:  state_nxt = S_IDLE;
         S_TOUT:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= S_IDLE;
         op_q     <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         fun_q    <= '0;
         idx_q    <= '0;
         ridx_q   <= 1'b0;
         rsp_buf  <= '0;
         Rsp_Data <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_q    <= Cmd_Op;
            addr_q  <= Cmd_Addr;
            data_q  <= Cmd_Data;
            opa_q   <= Cmd_OPA;
            opb_q   <= Cmd_OPB;
            fun_q   <= Cmd_FUN;
            idx_q   <= '0;
            ridx_q  <= 1'b0;
            rsp_buf <= '0;
         end
         if (xfer && !tx_last) idx_q <= idx_q + 2'd1;
         if (rx_take) begin
            rsp_buf <= buf_nxt;
            ridx_q  <= ridx_q + 1'b1;
         end
         // Publish on completion only, so the last result holds meanwhile.
         if (state_nxt == S_DONE || state_nxt == S_TOUT)
            Rsp_Data <= buf_nxt;
      end
   end

   assign Cmd_Ready = (state == S_IDLE);
   assign TX_D_VLD  = (state == S_SEND);
   assign TX_P_DATA = TX_D_VLD ? frame_byte : '0;
   assign Rsp_Valid = (state == S_DONE);
`ifdef SYS_CMD_TIMEOUT_EN
   assign Rsp_Timeout = (state == S_TOUT);
`else
   assign Rsp_Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sys_cmd_master.sv
`timescale 1ns/1ps
// tb_sys_cmd_master: vector table of full commands plus hand-written
// sequences for busy hold, ignored inputs, timeout and reset.
module tb_sys_cmd_master;

   logic        CLK = 1'b0;
   logic        RST;
   logic        Cmd_Valid;
   logic        Cmd_Ready;
   logic [1:0]  Cmd_Op;
   logic [3:0]  Cmd_Addr;
   logic [7:0]  Cmd_Data;
   logic [7:0]  Cmd_OPA;
   logic [7:0]  Cmd_OPB;
   logic [3:0]  Cmd_FUN;
   logic [15:0] Timeout_Lim;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;
   logic        TX_Busy;
   logic [7:0]  RX_P_DATA;
   logic        RX_D_VLD;
   logic        Rsp_Valid;
   logic [15:0] Rsp_Data;
   logic        Rsp_Timeout;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   sys_cmd_master dut (
      .CLK(CLK), .RST(RST),
      .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
      .Cmd_Op(Cmd_Op), .Cmd_Addr(Cmd_Addr), .Cmd_Data(Cmd_Data),
      .Cmd_OPA(Cmd_OPA), .Cmd_OPB(Cmd_OPB), .Cmd_FUN(Cmd_FUN),
      .Timeout_Lim(Timeout_Lim),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_Busy(TX_Busy),
      .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .Rsp_Valid(Rsp_Valid), .Rsp_Data(Rsp_Data),
      .Rsp_Timeout(Rsp_Timeout)
   );

   typedef struct packed {
      logic [1:0]      op;
      logic [3:0]      addr;
      logic [7:0]      data;
      logic [7:0]      opa;
      logic [7:0]      opb;
      logic [3:0]      fun;
      logic [2:0]      nb;
      logic [3:0][7:0] b;
      logic [1:0]      nrx;
      logic [15:0]     r;
      logic [15:0]     rsp;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [3:0] addr,
                        input logic [7:0] data, input logic [7:0] opa,
                        input logic [7:0] opb, input logic [3:0] fun);
      check("cmd_ready_before", Cmd_Ready, 1);
      Cmd_Valid = 1'b1;
      Cmd_Op    = op;
      Cmd_Addr  = addr;
      Cmd_Data  = data;
      Cmd_OPA   = opa;
      Cmd_OPB   = opb;
      Cmd_FUN   = fun;
      tick();
      Cmd_Valid = 1'b0;
      Cmd_Op    = ~op;
      Cmd_Addr  = ~addr;
      Cmd_Data  = ~data;
      Cmd_OPA   = ~opa;
      Cmd_OPB   = ~opb;
      Cmd_FUN   = ~fun;
   endtask

   // Plays the transmitter: optional busy window after each transfer.
   task automatic tx_frame(input int nb, input logic [3:0][7:0] b,
                           input int busy_len, input bit inject);
      int wait_n;
      for (int i = 0; i < nb; i++) begin
         check($sformatf("tx_vld_%0d", i), TX_D_VLD, 1);
         check($sformatf("tx_byte_%0d", i), TX_P_DATA, b[i]);
         wait_n = (i == 0) ? 0 : busy_len;
         for (int k = 0; k < wait_n; k++) begin
            if (inject && i == 1 && k == 0) begin
               RX_D_VLD  = 1'b1;
               RX_P_DATA = 8'hEE;
            end
            tick();
            RX_D_VLD = 1'b0;
         end
         if (wait_n > 0) begin
            check($sformatf("tx_held_vld_%0d", i), TX_D_VLD, 1);
            check($sformatf("tx_held_byte_%0d", i), TX_P_DATA, b[i]);
         end
         TX_Busy = 1'b0;
         tick();
         if (i < nb - 1) begin
            TX_Busy = (busy_len > 0);
            check($sformatf("tx_gap_%0d", i), TX_D_VLD, 0);
            tick();
         end
      end
   endtask

   task automatic rx_byte(input logic [7:0] v);
      RX_P_DATA = v;
      RX_D_VLD  = 1'b1;
      tick();
      RX_D_VLD  = 1'b0;
      RX_P_DATA = 8'h5A;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int seen;
      int k;
      vecs[0] = '{op:2'b00, addr:4'h5, data:8'h3C, opa:8'h00, opb:8'h00,
                  fun:4'h0, nb:3'd3, b:32'h003C05AA, nrx:2'd0,
                  r:16'h0000, rsp:16'h0000};
      vecs[1] = '{op:2'b01, addr:4'h2, data:8'h99, opa:8'h11, opb:8'h22,
                  fun:4'h7, nb:3'd2, b:32'h000002BB, nrx:2'd1,
                  r:16'h0077, rsp:16'h0077};
      vecs[2] = '{op:2'b10, addr:4'h9, data:8'h00, opa:8'h12, opb:8'h34,
                  fun:4'h1, nb:3'd4, b:32'h013412CC, nrx:2'd2,
                  r:16'h0046, rsp:16'h0046};
      vecs[3] = '{op:2'b11, addr:4'h3, data:8'h44, opa:8'h55, opb:8'h66,
                  fun:4'h2, nb:3'd2, b:32'h000002DD, nrx:2'd2,
                  r:16'h2211, rsp:16'h2211};
      vecs[4] = '{op:2'b00, addr:4'hF, data:8'hFF, opa:8'h00, opb:8'h00,
                  fun:4'h0, nb:3'd3, b:32'h00FF0FAA, nrx:2'd0,
                  r:16'h0000, rsp:16'h0000};
      vecs[5] = '{op:2'b10, addr:4'h0, data:8'h00, opa:8'hA5, opb:8'h5A,
                  fun:4'hF, nb:3'd4, b:32'h0F5AA5CC, nrx:2'd2,
                  r:16'h1234, rsp:16'h1234};
      vecs[6] = '{op:2'b01, addr:4'h0, data:8'h00, opa:8'h00, opb:8'h00,
                  fun:4'h0, nb:3'd2, b:32'h000000BB, nrx:2'd1,
                  r:16'h00C3, rsp:16'h00C3};

      RST = 1'b0;
      Cmd_Valid = 1'b0; Cmd_Op = '0; Cmd_Addr = '0; Cmd_Data = '0;
      Cmd_OPA = '0; Cmd_OPB = '0; Cmd_FUN = '0; Timeout_Lim = '0;
      TX_Busy = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0;
      #2;
      check("rst_cmd_ready", Cmd_Ready, 1);
      check("rst_tx_vld", TX_D_VLD, 0);
      check("rst_tx_data", TX_P_DATA, 0);
      check("rst_rsp_valid", Rsp_Valid, 0);
      check("rst_rsp_data", Rsp_Data, 0);
      check("rst_rsp_tout", Rsp_Timeout, 0);
      tick();
      @(negedge CLK);
      RST = 1'b1;
      tick();

      // Vector table: TX_Busy held low, replies a few cycles later
      foreach (vecs[n]) begin
         issue(vecs[n].op, vecs[n].addr, vecs[n].data,
               vecs[n].opa, vecs[n].opb, vecs[n].fun);
         tx_frame(int'(vecs[n].nb), vecs[n].b, 0, 1'b0);
         if (vecs[n].nrx != 0) begin
            check($sformatf("v%0d_wait_no_valid", n), Rsp_Valid, 0);
            tick();
            tick();
            check($sformatf("v%0d_wait_busy", n), Cmd_Ready, 0);
            rx_byte(vecs[n].r[7:0]);
            if (vecs[n].nrx == 2) begin
               check($sformatf("v%0d_mid_no_valid", n), Rsp_Valid, 0);
               tick();
               rx_byte(vecs[n].r[15:8]);
            end
         end
         check($sformatf("v%0d_rsp_valid", n), Rsp_Valid, 1);
         check($sformatf("v%0d_rsp_data", n), Rsp_Data, vecs[n].rsp);
         tick();
         check($sformatf("v%0d_pulse_one", n), Rsp_Valid, 0);
         check($sformatf("v%0d_ready_back", n), Cmd_Ready, 1);
         check($sformatf("v%0d_rsp_hold", n), Rsp_Data, vecs[n].rsp);
      end

      // Busy transmitter, stray RX during SEND, Cmd_Valid during WAIT_RSP
      issue(2'b10, 4'h0, 8'h00, 8'h12, 8'h34, 4'h1);
      tx_frame(4, 32'h013412CC, 20, 1'b1);
      Cmd_Valid = 1'b1;
      Cmd_Op    = 2'b00;
      check("busy_wait_ready", Cmd_Ready, 0);
      tick();
      Cmd_Valid = 1'b0;
      check("busy_wait_no_tx", TX_D_VLD, 0);
      repeat (5) tick();
      rx_byte(8'h46);
      tick();
      rx_byte(8'h00);
      check("busy_rsp_valid", Rsp_Valid, 1);
      check("busy_rsp_data", Rsp_Data, 16'h0046);
      tick();
      check("busy_ready_back", Cmd_Ready, 1);
      check("busy_not_queued", TX_D_VLD, 0);

      // Partial DD response with Timeout_Lim=50
      Timeout_Lim = 16'd50;
      issue(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2);
      tx_frame(2, 32'h000002DD, 0, 1'b0);
      repeat (3) tick();
      rx_byte(8'hAB);
`ifdef SYS_CMD_TIMEOUT_EN
      k = 0;
      while (Rsp_Timeout !== 1'b1 && k < 200) begin
         tick();
         k++;
      end
      check("tout_delay", k, 50);
      check("tout_data", Rsp_Data, 16'h00AB);
      check("tout_no_valid", Rsp_Valid, 0);
      tick();
      check("tout_pulse_one", Rsp_Timeout, 0);
      check("tout_ready_back", Cmd_Ready, 1);
`else
      seen = 0;
      repeat (200) begin
         tick();
         if (Rsp_Timeout || Rsp_Valid) seen++;
      end
      check("notout_quiet", seen, 0);
      rx_byte(8'hCD);
      check("notout_valid", Rsp_Valid, 1);
      check("notout_data", Rsp_Data, 16'hCDAB);
      tick();
`endif

      // Timeout_Lim=0 never times out
      Timeout_Lim = 16'd0;
      issue(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2);
      tx_frame(2, 32'h000002DD, 0, 1'b0);
      rx_byte(8'hAB);
      seen = 0;
      repeat (1000) begin
         tick();
         if (Rsp_Timeout || Rsp_Valid) seen++;
      end
      check("lim0_quiet", seen, 0);
      rx_byte(8'hCD);
      check("lim0_valid", Rsp_Valid, 1);
      check("lim0_data", Rsp_Data, 16'hCDAB);
      tick();

      // Bytes landing exactly on the terminal count win
      Timeout_Lim = 16'd5;
      issue(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3);
      tx_frame(2, 32'h000003DD, 0, 1'b0);
      seen = 0;
      repeat (4) begin
         tick();
         if (Rsp_Timeout) seen++;
      end
      rx_byte(8'h10);
      check("term_first_no_tout", Rsp_Timeout, 0);
      check("term_first_no_valid", Rsp_Valid, 0);
      repeat (4) begin
         tick();
         if (Rsp_Timeout) seen++;
      end
      check("term_quiet", seen, 0);
      rx_byte(8'h20);
      check("term_no_tout", Rsp_Timeout, 0);
      check("term_valid", Rsp_Valid, 1);
      check("term_data", Rsp_Data, 16'h2010);
      tick();
      Timeout_Lim = 16'd0;

      // Reset in the middle of a CC frame
      issue(2'b10, 4'h0, 8'h00, 8'hA1, 8'hB2, 4'h3);
      tick();
      tick();
      check("mid_send_vld", TX_D_VLD, 1);
      #2;
      RST = 1'b0;
      #1;
      check("arst_cmd_ready", Cmd_Ready, 1);
      check("arst_tx_vld", TX_D_VLD, 0);
      check("arst_tx_data", TX_P_DATA, 0);
      check("arst_rsp_valid", Rsp_Valid, 0);
      check("arst_rsp_data", Rsp_Data, 0);
      check("arst_rsp_tout", Rsp_Timeout, 0);
      tick();
      #3;
      RST = 1'b1;
      tick();
      check("post_rst_ready", Cmd_Ready, 1);
      check("post_rst_tx_vld", TX_D_VLD, 0);
      check("post_rst_no_rsp", Rsp_Valid, 0);
      issue(2'b01, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0);
      tx_frame(2, 32'h000007BB, 0, 1'b0);
      rx_byte(8'h5E);
      check("post_rst_valid", Rsp_Valid, 1);
      check("post_rst_data", Rsp_Data, 16'h005E);
      tick();
      check("post_rst_ready_end", Cmd_Ready, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sys_cmd_master.md
# sys_cmd_master

Host-side command initiator for the system controller's UART command protocol. It accepts one command request at a time, serializes it into the protocol byte frame (0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands), and feeds the bytes to a UART transmitter through a valid/busy handshake. It then collects the response bytes from a UART receiver, assembles the result, and reports completion or timeout. It sits on the far end of the serial link from the system controller, in the test harness and host-emulation path.

## Interface
Parameters:
- D_Width, 8, frame byte width
- ALU_O_W, D_Width*2, result width
- Addr_Size, 4, register-file address width; zero-extended to D_Width in the frame
- TO_W, 16, timeout counter width

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- Cmd_Valid  in  1  command request
- Cmd_Ready  out  1  block idle, command accepted when Cmd_Valid && Cmd_Ready at a rising edge
- Cmd_Op  in  2  opcode: 00 → 0xAA, 01 → 0xBB, 10 → 0xCC, 11 → 0xDD
- Cmd_Addr  in  Addr_Size  register address (AA/BB)
- Cmd_Data  in  D_Width  write data (AA)
- Cmd_OPA, Cmd_OPB  in  D_Width each  ALU operands (CC)
- Cmd_FUN  in  4  ALU function (CC/DD); zero-extended in the frame
- Timeout_Lim  in  TO_W  response timeout in cycles; 0 disables the timeout
- TX_P_DATA  out  D_Width  byte to transmitter
- TX_D_VLD  out  1  byte valid
- TX_Busy  in  1  transmitter busy
- RX_P_DATA  in  D_Width  received byte
- RX_D_VLD  in  1  one-cycle pulse per received byte
- Rsp_Valid  out  1  one-cycle completion pulse
- Rsp_Data  out  ALU_O_W  assembled response
- Rsp_Timeout  out  1  one-cycle timeout pulse

## Operation
- Frames: AA: {AA, addr, data}, 3 bytes, 0 response bytes. BB: {BB, addr}, 2 bytes, 1 response byte. CC: {CC, OPA, OPB, FUN}, 4 bytes, 2 response bytes. DD: {DD, FUN}, 2 bytes, 2 response bytes.
- Response assembly: responses arrive LSB first. BB sets Rsp_Data = {8'h00, b0}. CC and DD set Rsp_Data = {b1, b0}. AA sets Rsp_Data = 0.
- All command fields are latched on acceptance. Later changes on the Cmd_* inputs have no effect.
- States:
  - IDLE: Cmd_Ready=1. On accept, go to SEND with byte index 0.
  - SEND: TX_D_VLD=1, TX_P_DATA=frame[idx]. A transfer happens at an edge where TX_D_VLD=1 and TX_Busy=0. After a non-last byte, go to GAP. After the last byte, go to WAIT_RSP, except AA, which goes to DONE.
  - GAP: exactly 1 cycle with TX_D_VLD=0, then back to SEND with idx+1.
  - WAIT_RSP: each RX_D_VLD stores RX_P_DATA at the response index and clears the timeout counter. When the last expected byte arrives, go to DONE. When the counter reaches Timeout_Lim (if nonzero), go to TOUT.
  - DONE: Rsp_Valid=1 for 1 cycle, then IDLE.
  - TOUT: Rsp_Timeout=1 for 1 cycle, Rsp_Data holds the partial bytes (missing bytes are 0), then IDLE.
- RX_D_VLD outside WAIT_RSP: the byte is discarded.
- Cmd_Valid while Cmd_Ready=0: ignored, not queued.
- The attached transmitter must assert TX_Busy no later than the cycle after a transfer. GAP relies on this.

## Timing
- Reset values: Cmd_Ready=1, TX_D_VLD=0, TX_P_DATA=0, Rsp_Valid=0, Rsp_Data=0, Rsp_Timeout=0. State IDLE, all counters 0.
- Outputs are registered or decoded directly from registered state. There is no combinational path from any input to any output.
- Accept edge → TX_D_VLD=1 with byte 0 on the next cycle.
- With TX_Busy held at 0, an N-byte frame completes in 2N-1 cycles of SEND/GAP.
- AA: Rsp_Valid in the cycle after the last transfer. Cmd_Ready=1 in the cycle after that.
- Last response byte edge → Rsp_Valid the next cycle. Rsp_Data is valid in that cycle and holds until the next command completes.
- Timeout: counter starts at 0 on entry to WAIT_RSP and increments each cycle without RX_D_VLD. TOUT is entered when counter == Timeout_Lim-1 and no byte arrives that cycle.
- RX_D_VLD in the same cycle as the terminal count: the byte wins. It is stored, the counter clears, and no timeout occurs.
- RST asserted mid-operation: immediate return to reset values. The in-flight command is dropped with no Rsp_* pulse.

## Configuration
- SYS_CMD_TIMEOUT_EN defined: timeout counter and TOUT state are present as described above.
- SYS_CMD_TIMEOUT_EN undefined:
  - No counter or TOUT logic.
  - Timeout_Lim is ignored; Rsp_Timeout is tied to 0.
  - WAIT_RSP waits indefinitely; only RST recovers.

## Test plan
- Op=00, Addr=5, Data=0x3C, TX_Busy=0 → bytes AA,05,3C each with one GAP between; Rsp_Valid one cycle after the 0x3C transfer with Rsp_Data=0x0000.
- Op=01, Addr=2, RX byte 0x77 after 10 cycles → bytes BB,02; Rsp_Valid with Rsp_Data=0x0077.
- Op=10, OPA=0x12, OPB=0x34, FUN=1, TX_Busy high 20 cycles after each transfer → bytes CC,12,34,01, each held until TX_Busy=0; RX 0x46 then 0x00 → Rsp_Data=0x0046.
- Op=11, FUN=2, Timeout_Lim=50, RX only 0xAB → Rsp_Timeout pulse 50 cycles after that byte, Rsp_Data=0x00AB. Repeat with Timeout_Lim=0 → no pulse within 1000 cycles.
- RX pulse during SEND, Cmd_Valid during WAIT_RSP → both ignored, response unaffected. RX byte on the terminal-count cycle → accepted, no timeout.
- RST low mid-SEND of a CC frame → all outputs at reset values, Cmd_Ready=1 after release, next command runs normally.
